si_tag_frame_tx: RTL and testbench
==================================

Name: si_tag_frame_tx

Overview:
Transmit-side framer for the FPGA-link Ethernet port. Accepts a stream of 64-bit words from user logic in the sys_clk domain and packs them into Ethernet frames: header beat, payload, zero padding to minimum length. Frames leave as a 128-bit AXI4-Stream towards the width-adapter/CDC FIFO feeding the 10G MAC TX path. FCS is appended downstream, not here.

Parameters:
MAX_WORDS, 180, payload words per frame before a forced close; range 6..2048, even.
TIMEOUT_CYCLES, 1024, idle cycles after the last accepted word before an open frame is closed; range 1..65535.

Ports:
clk  in  1  sys_clk.
rst  in  1  synchronous, active-high reset.
cfg_enable  in  1  permits new frames to open.
cfg_dst_mac  in  48  destination MAC, [47:40] sent first.
cfg_src_mac  in  48  source MAC, [47:40] sent first.
cfg_ethertype  in  16  EtherType, [15:8] sent first.
s_axis_tvalid  in  1  input word valid.
s_axis_tready  out  1  input word accepted.
s_axis_tdata  in  64  payload word.
s_axis_tlast  in  1  close the frame after this word.
m_axis_tvalid  out  1  output beat valid.
m_axis_tready  in  1  downstream ready.
m_axis_tdata  out  128  output beat; byte 0 is [7:0].
m_axis_tkeep  out  16  byte enables.
m_axis_tlast  out  1  last beat of frame.
frame_seq  out  16  sequence number of the next frame.

Behaviour:
- Reset values:
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tkeep=0.
  - s_axis_tready=0, frame_seq=0.
  - FSM in IDLE; all counters cleared.
- Reset mid-frame: tvalid drops on the next edge and the partial frame is abandoned. The downstream FIFO is reset together with this block.
- Header beat: bytes 0-5 dst MAC, bytes 6-11 src MAC, bytes 12-13 EtherType, bytes 14-15 frame_seq big-endian. tkeep=16'hFFFF.
- Payload beat: word n at [63:0], word n+1 at [127:64]. A beat holding a single word has tkeep=16'h00FF and [127:64]=0.
- Output handshake: tvalid, once asserted, holds with stable data until tready. tkeep is never 0 while tvalid=1.
- s_axis_tready is asserted only in COLLECT and only when the beat register can take a word.
- FSM:
  - IDLE: wait for s_axis_tvalid and cfg_enable. Latch the config fields, then go to HEADER. The first word is not consumed in IDLE.
  - HEADER: present the header beat. On handshake go to COLLECT.
  - COLLECT:
    - Accept words into a two-word beat register.
    - A full beat is held pending; it is presented with tlast=0 only once the next word is accepted. This one-beat lookahead lets tlast be set correctly.
    - Close events: accepted word has s_axis_tlast=1; word count reaches MAX_WORDS; idle counter reaches TIMEOUT_CYCLES. On a close event go to FLUSH.
    - If a close event and a new word coincide, the word is not accepted; tready is low that cycle.
  - FLUSH:
    - Present the final beat, which may be partial.
    - tlast=1 if at least 3 payload beats have been sent, including this one. Otherwise tlast=0 and go to PAD.
  - PAD: present all-zero beats with tkeep=16'hFFFF. Set tlast on the 3rd payload beat. Minimum frame is 64 bytes before FCS.
  - After a final-beat handshake: frame_seq increments (65535 wraps to 0) and the FSM returns to IDLE.
- Idle counter: 16 bit. Cleared on every accepted word; counts only in COLLECT; saturates.
- cfg_enable deasserted mid-frame: the open frame completes normally; no new frame opens.
- Config changes mid-frame take effect at the next frame.
- Latency: first word accepted 2 cycles after tvalid in IDLE, given tready=1 throughout.

Optional Feature:
SI_FRAME_TX_STATS_EN
- Defined:
  - Adds stat_frames[31:0]: frames completed, +1 per final-beat handshake.
  - Adds stat_words[31:0]: accepted input words.
  - Adds stat_timeouts[31:0]: closes caused by timeout.
  - All three are wrapping counters, reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Enable, dst=02:00:00:00:00:01, src=02:00:00:00:00:02, ethertype=0x88B5, send words 1..4 with tlast on word 4 -> header beat with seq 0x0000; beats {2,1},{4,3}; one zero beat with tlast; frame_seq=1.
- Send 5 words, no tlast, then idle -> after 1024 idle cycles, beats {2,1},{4,3}, then {0,5} with tkeep=16'h00FF and tlast=1.
- Stream 400 words continuously, tlast on word 400 -> frames of 180, 180 and 40 words; seq 0,1,2; no padding beats.
- Random m_axis_tready, 50% duty, over 1000 words -> output beats stable while stalled; word order and count exact.
- Assert rst mid-payload -> next edge: tvalid=0, tready=0, frame_seq=0; the next frame starts with a fresh header.
- Force frame_seq=65535 and send one frame -> header carries 0xFFFF; afterwards frame_seq=0.

Source files
------------

// File: rtl/si_tag_frame_tx.sv
// si_tag_frame_tx: packs 64-bit user words into Ethernet frames (header, payload pairs, zero pad to 64 B) on a 128-bit AXI4-Stream.
// Latency: header beat valid one cycle after a word is offered in IDLE; first word accepted two cycles after it is offered.
// Backpressure: an output beat holds until m_axis_tready; s_axis_tready drops while the pending beat cannot drain.
// Optional: define SI_FRAME_TX_STATS_EN to add stat_frames / stat_words / stat_timeouts counters.

module si_tag_frame_tx #(
    parameter int MAX_WORDS      = 180,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cfg_enable,
    input  logic [47:0]  cfg_dst_mac,
    input  logic [47:0]  cfg_src_mac,
    input  logic [15:0]  cfg_ethertype,
    input  logic         s_axis_tvalid,
    output logic         s_axis_tready,
    input  logic [63:0]  s_axis_tdata,
    input  logic         s_axis_tlast,
    output logic         m_axis_tvalid,
    input  logic         m_axis_tready,
    output logic [127:0] m_axis_tdata,
    output logic [15:0]  m_axis_tkeep,
    output logic         m_axis_tlast,
`ifdef SI_FRAME_TX_STATS_EN
    output logic [31:0]  stat_frames,
    output logic [31:0]  stat_words,
    output logic [31:0]  stat_timeouts,
`endif
    output logic [15:0]  frame_seq
);

    localparam logic [11:0] MAX_LIM = 12'(MAX_WORDS);
    localparam logic [15:0] TO_LIM  = 16'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {S_IDLE, S_HEADER, S_COLLECT, S_FLUSH, S_PAD} state_t;

    state_t        state_q, state_d;
    logic [63:0]   w0_q, w0_d, w1_q, w1_d;     // two-word beat register
    logic [1:0]    cnt_q, cnt_d;               // words held in the beat register
    logic [11:0]   words_q, words_d;           // payload words accepted this frame
    logic [15:0]   idle_q, idle_d;             // cycles since last accepted word
    logic [1:0]    beats_q, beats_d;           // payload beats loaded, saturates at 3
    logic [15:0]   frame_seq_q, seq_d;
    logic          m_vld_q, vld_d, m_last_q, last_d;
    logic [127:0]  m_dat_q, dat_d, hdr;
    logic [15:0]   m_keep_q, keep_d;

    logic          out_free, timeout_hit, accept;
    logic [1:0]    beat_inc;
    logic [11:0]   words_inc;

    assign out_free      = !m_vld_q || m_axis_tready;
    assign timeout_hit   = (idle_q >= TO_LIM);
    assign s_axis_tready = (state_q == S_COLLECT) && !timeout_hit && ((cnt_q != 2'd2) || out_free);
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign beat_inc      = (beats_q == 2'd3) ? 2'd3 : beats_q + 2'd1;
    assign words_inc     = words_q + 12'd1;

    assign m_axis_tvalid = m_vld_q;
    assign m_axis_tdata  = m_dat_q;
    assign m_axis_tkeep  = m_keep_q;
    assign m_axis_tlast  = m_last_q;
    assign frame_seq     = frame_seq_q;

    // Header beat assembled from live config; it is captured into the output register on leaving IDLE.
    always_comb begin
        hdr = '0;
        for (int i = 0; i < 6; i++) begin
            hdr[8*i +: 8]      = cfg_dst_mac[8*(5-i) +: 8];
            hdr[48+8*i +: 8]   = cfg_src_mac[8*(5-i) +: 8];
        end
        hdr[103:96]  = cfg_ethertype[15:8];
        hdr[111:104] = cfg_ethertype[7:0];
        hdr[119:112] = frame_seq_q[15:8];
        hdr[127:120] = frame_seq_q[7:0];
    end

    // Next-state and datapath: every output-register load is gated on the register being free.
    always_comb begin
        state_d = state_q;
        w0_d    = w0_q;
        w1_d    = w1_q;
        cnt_d   = cnt_q;
        words_d = words_q;
        idle_d  = idle_q;
        beats_d = beats_q;
        seq_d   = frame_seq_q;
        vld_d   = m_vld_q;
        dat_d   = m_dat_q;
        keep_d  = m_keep_q;
        last_d  = m_last_q;
        if (m_vld_q && m_axis_tready) vld_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (s_axis_tvalid && cfg_enable) begin
                    vld_d   = 1'b1;
                    dat_d   = hdr;
                    keep_d  = 16'hFFFF;
                    last_d  = 1'b0;
                    cnt_d   = 2'd0;
                    words_d = '0;
                    idle_d  = '0;
                    beats_d = 2'd0;
                    state_d = S_HEADER;
                end
            end
            S_HEADER: begin
                if (m_vld_q && m_axis_tready) state_d = S_COLLECT;
            end
            S_COLLECT: begin
                if (accept) begin
                    idle_d  = '0;
                    words_d = words_inc;
                    if (cnt_q == 2'd2) begin
                        // A new word proves the held pair is not the last one.
                        vld_d   = 1'b1;
                        dat_d   = {w1_q, w0_q};
                        keep_d  = 16'hFFFF;
                        last_d  = 1'b0;
                        beats_d = beat_inc;
                        w0_d    = s_axis_tdata;
                        cnt_d   = 2'd1;
                    end else if (cnt_q == 2'd1) begin
                        w1_d  = s_axis_tdata;
                        cnt_d = 2'd2;
                    end else begin
                        w0_d  = s_axis_tdata;
                        cnt_d = 2'd1;
                    end
                    if (s_axis_tlast || (words_inc == MAX_LIM)) state_d = S_FLUSH;
                end else if (timeout_hit) begin
                    // No words at all: nothing to flush, go straight to padding.
                    state_d = (cnt_q == 2'd0) ? S_PAD : S_FLUSH;
                end else if (idle_q != 16'hFFFF) begin
                    idle_d = idle_q + 16'd1;
                end
            end
            S_FLUSH: begin
                if (out_free) begin
                    vld_d   = 1'b1;
                    dat_d   = (cnt_q == 2'd2) ? {w1_q, w0_q} : {64'h0, w0_q};
                    keep_d  = (cnt_q == 2'd2) ? 16'hFFFF : 16'h00FF;
                    last_d  = (beats_q >= 2'd2);
                    beats_d = beat_inc;
                    state_d = S_PAD;
                end
            end
            S_PAD: begin
                // beats_q == 3 means the tlast beat is already loaded; just wait for it to go.
                if (m_vld_q && m_axis_tready && m_last_q) begin
                    seq_d   = frame_seq_q + 16'd1;
                    state_d = S_IDLE;
                end else if (out_free && (beats_q != 2'd3)) begin
                    vld_d   = 1'b1;
                    dat_d   = '0;
                    keep_d  = 16'hFFFF;
                    last_d  = (beats_q == 2'd2);
                    beats_d = beat_inc;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            w0_q        <= '0;
            w1_q        <= '0;
            cnt_q       <= 2'd0;
            words_q     <= '0;
            idle_q      <= '0;
            beats_q     <= 2'd0;
            frame_seq_q <= '0;
            m_vld_q     <= 1'b0;
            m_dat_q     <= '0;
            m_keep_q    <= '0;
            m_last_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            w0_q        <= w0_d;
            w1_q        <= w1_d;
            cnt_q       <= cnt_d;
            words_q     <= words_d;
            idle_q      <= idle_d;
            beats_q     <= beats_d;
            frame_seq_q <= seq_d;
            m_vld_q     <= vld_d;
            m_dat_q     <= dat_d;
            m_keep_q    <= keep_d;
            m_last_q    <= last_d;
        end
    end

`ifdef SI_FRAME_TX_STATS_EN
    logic [31:0] st_frames_q, st_words_q, st_timeouts_q;

    // Wrapping event counters: completed frames, accepted words, timeout closes.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_frames_q   <= '0;
            st_words_q    <= '0;
            st_timeouts_q <= '0;
        end else begin
            if (m_vld_q && m_axis_tready && m_last_q) st_frames_q <= st_frames_q + 32'd1;
            if (accept) st_words_q <= st_words_q + 32'd1;
            if ((state_q == S_COLLECT) && timeout_hit) st_timeouts_q <= st_timeouts_q + 32'd1;
        end
    end

    assign stat_frames   = st_frames_q;
    assign stat_words    = st_words_q;
    assign stat_timeouts = st_timeouts_q;
`endif

endmodule

// File: tb/tb_si_tag_frame_tx.sv
// tb_si_tag_frame_tx: directed + randomized stimulus against a frame-level reference model.
// Latency: n/a (testbench).
// Backpressure: m_axis_tready driven high or randomized at 50% duty.

module tb_si_tag_frame_tx;

    localparam int MAXW = 180;

    logic         clk = 1'b0;
    logic         rst;
    logic         cfg_enable;
    logic [47:0]  cfg_dst_mac, cfg_src_mac;
    logic [15:0]  cfg_ethertype;
    logic         s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [63:0]  s_axis_tdata;
    logic         m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [127:0] m_axis_tdata;
    logic [15:0]  m_axis_tkeep;
    logic [15:0]  frame_seq;
`ifdef SI_FRAME_TX_STATS_EN
    logic [31:0]  stat_frames, stat_words, stat_timeouts;
`endif

    always #5 clk = ~clk;

    si_tag_frame_tx #(.MAX_WORDS(MAXW), .TIMEOUT_CYCLES(1024)) dut (
        .clk(clk), .rst(rst), .cfg_enable(cfg_enable),
        .cfg_dst_mac(cfg_dst_mac), .cfg_src_mac(cfg_src_mac), .cfg_ethertype(cfg_ethertype),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
`ifdef SI_FRAME_TX_STATS_EN
        .stat_frames(stat_frames), .stat_words(stat_words), .stat_timeouts(stat_timeouts),
`endif
        .frame_seq(frame_seq)
    );

    typedef struct packed {
        logic         l;
        logic [15:0]  k;
        logic [127:0] d;
    } beat_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    beat_t       act_q[$];
    beat_t       exp_q[$];
    logic [63:0] fw[$];
    logic [127:0] cur_hdr;
    bit          open_f = 1'b0;
    logic [15:0] mseq = '0;
    bit          rand_rdy = 1'b0;
    bit          stall_prev = 1'b0;
    beat_t       stall_beat;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Header straight from the byte layout: dst, src, ethertype, sequence, all big-endian on the wire.
    function automatic logic [127:0] make_hdr(input logic [15:0] seq);
        logic [7:0]   b[16];
        logic [127:0] h;
        for (int i = 0; i < 6; i++) begin
            b[i]     = 8'(cfg_dst_mac >> (8 * (5 - i)));
            b[6 + i] = 8'(cfg_src_mac >> (8 * (5 - i)));
        end
        b[12] = cfg_ethertype[15:8];
        b[13] = cfg_ethertype[7:0];
        b[14] = seq[15:8];
        b[15] = seq[7:0];
        h = '0;
        for (int i = 0; i < 16; i++) h[8*i +: 8] = b[i];
        return h;
    endfunction

    task automatic model_open();
        cur_hdr = make_hdr(mseq);
        mseq    = mseq + 16'd1;
        open_f  = 1'b1;
    endtask

    // A finished frame: header, words two per beat, zero beats until 3 payload beats, tlast on the final one.
    task automatic model_close();
        int    n, nb, total;
        beat_t b;
        n     = fw.size();
        nb    = (n + 1) / 2;
        total = (nb < 3) ? 3 : nb;
        b.d = cur_hdr; b.k = 16'hFFFF; b.l = 1'b0;
        exp_q.push_back(b);
        for (int i = 0; i < total; i++) begin
            if (2*i + 1 < n)      begin b.d = {fw[2*i+1], fw[2*i]}; b.k = 16'hFFFF; end
            else if (2*i < n)     begin b.d = {64'h0, fw[2*i]};     b.k = 16'h00FF; end
            else                  begin b.d = '0;                    b.k = 16'hFFFF; end
            b.l = (i == total - 1);
            exp_q.push_back(b);
        end
        fw.delete();
        open_f = 1'b0;
    endtask

    task automatic model_push(input logic [63:0] w, input logic last);
        fw.push_back(w);
        if (last || fw.size() == MAXW) model_close();
    endtask

    // One clock: inputs change 1 ns after the rising edge, outputs observed on the falling edge.
    task automatic cycle();
        beat_t cur;
        @(posedge clk);
        #1;
        m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        cur.d = m_axis_tdata; cur.k = m_axis_tkeep; cur.l = m_axis_tlast;
        if (stall_prev)
            chk("stall_hold", 160'({m_axis_tvalid, cur}), 160'({1'b1, stall_beat}));
        if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) act_q.push_back(cur);
        stall_prev = (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b0);
        stall_beat = cur;
    endtask

    task automatic send_word(input logic [63:0] w, input logic last, output int waited);
        bit acc = 1'b0;
        if (!open_f) model_open();
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = w;
        s_axis_tlast  = last;
        waited = 0;
        while (!acc && waited < 300) begin
            if (s_axis_tready === 1'b1) acc = 1'b1;
            else waited++;
            cycle();
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        chk("word_accepted", 160'(acc), 160'(1));
        if (acc) model_push(w, last);
    endtask

    task automatic drain_and_compare(input string tag);
        int k = 0;
        while (act_q.size() < exp_q.size() && k < 20000) begin
            cycle();
            k++;
        end
        chk({tag, "_drain_in_time"}, 160'(act_q.size() >= exp_q.size()), 160'(1));
        repeat (4) cycle();
        chk({tag, "_beat_count"}, 160'(act_q.size()), 160'(exp_q.size()));
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_beat%0d", tag, i), 160'(act_q[i]), 160'(exp_q[i]));
        act_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst = 1'b1; cfg_enable = 1'b1;
        cfg_dst_mac = 48'h02_00_00_00_00_01;
        cfg_src_mac = 48'h02_00_00_00_00_02;
        cfg_ethertype = 16'h88B5;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
        m_axis_tready = 1'b1;

        // Reset state
        repeat (3) cycle();
        chk("rst_tvalid", 160'(m_axis_tvalid), 160'(0));
        chk("rst_tlast",  160'(m_axis_tlast),  160'(0));
        chk("rst_tdata",  160'(m_axis_tdata),  160'(0));
        chk("rst_tkeep",  160'(m_axis_tkeep),  160'(0));
        chk("rst_tready", 160'(s_axis_tready), 160'(0));
        chk("rst_seq",    160'(frame_seq),     160'(0));
        rst = 1'b0;
        cycle();

        // Four words, tlast on the fourth: padded to three payload beats
        for (int i = 1; i <= 4; i++) begin
            send_word(64'(i), i == 4, lat);
            if (i == 1) chk("first_word_latency", 160'(lat), 160'(2));
        end
        drain_and_compare("t1");
        chk("t1_seq", 160'(frame_seq), 160'(mseq));

        // Five words then silence: closes on timeout with a half-filled final beat
        for (int i = 1; i <= 5; i++) send_word(64'(i), 1'b0, lat);
        repeat (1000) cycle();
        chk("t2_no_early_close", 160'(act_q.size()), 160'(3));
        model_close();
        drain_and_compare("t2");
        chk("t2_seq", 160'(frame_seq), 160'(mseq));

        // 400 words back to back: forced closes at 180 and 360
        for (int i = 0; i < 400; i++) send_word(64'h1000 + 64'(i), i == 399, lat);
        drain_and_compare("t3");
        chk("t3_seq", 160'(frame_seq), 160'(mseq));

        // cfg_enable low: a waiting word must not open a frame
        cfg_enable = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata = 64'hDEAD;
        repeat (20) cycle();
        chk("dis_no_beats", 160'(act_q.size()), 160'(0));
        chk("dis_tready",   160'(s_axis_tready), 160'(0));
        cfg_enable = 1'b1;

        // 1000 random words, random gaps, random downstream ready, config change mid-run
        rand_rdy = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            send_word({$urandom, $urandom}, (i == 999) || ($urandom_range(0, 39) == 0), lat);
            if (i == 500) begin
                cfg_src_mac   = 48'hAA_BB_CC_DD_EE_FF;
                cfg_ethertype = 16'h0800;
            end
            repeat ($urandom_range(0, 2)) cycle();
        end
        rand_rdy = 1'b0;
        drain_and_compare("t4");
        chk("t4_seq", 160'(frame_seq), 160'(mseq));

        // Reset in the middle of a payload
        for (int i = 1; i <= 3; i++) send_word(64'(i), 1'b0, lat);
        rst = 1'b1;
        cycle();
        chk("midrst_tvalid", 160'(m_axis_tvalid), 160'(0));
        chk("midrst_tready", 160'(s_axis_tready), 160'(0));
        chk("midrst_seq",    160'(frame_seq),     160'(0));
        rst = 1'b0;
        act_q.delete(); exp_q.delete(); fw.delete();
        open_f = 1'b0; mseq = '0;
        cycle();
        send_word(64'h11, 1'b0, lat);
        send_word(64'h22, 1'b1, lat);
        drain_and_compare("t5");
        chk("t5_seq", 160'(frame_seq), 160'(mseq));

        // Sequence wrap from 0xFFFF
        force dut.frame_seq_q = 16'hFFFF;
        cycle();
        release dut.frame_seq_q;
        cycle();
        chk("wrap_pre", 160'(frame_seq), 160'(16'hFFFF));
        mseq = 16'hFFFF;
        send_word(64'h77, 1'b1, lat);
        drain_and_compare("t6");
        chk("wrap_post", 160'(frame_seq), 160'(mseq));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
